// File: rtl/rfx8_pll_sequencer.sv
// rfx8_pll_sequencer: PLL reset pulse, lock qualification, timeout retry/fault and loss-of-lock tracking.
module rfx8_pll_sequencer #(
    parameter int RST_CYCLES     = 8,
    parameter int STABLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       pll_ready,
    output logic       fault,
    output logic [7:0] lol_count,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        RST_ASSERT = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        READY      = 3'd3,
        FAULT      = 3'd4
    } state_t;

    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] STB_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  MAX_R    = 4'(MAX_RETRIES);

    logic [1:0]  rst_sync, lock_sync;
    logic        rst_go, locked_s;
    state_t      st, st_n;
    logic [15:0] cnt, cnt_n;
    logic [3:0]  retry, retry_n, retry_inc;
    logic [7:0]  lol_n;

    assign rst_go    = rst_sync[1];
    assign locked_s  = lock_sync[1];
    assign retry_inc = retry + 4'd1;
    assign state     = st;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync  <= '0;
            lock_sync <= '0;
        end else begin
            rst_sync  <= {rst_sync[0], 1'b1};
            lock_sync <= {lock_sync[0], pll_locked};
        end
    end

    always_comb begin
        st_n    = st;
        cnt_n   = cnt + 16'd1;
        retry_n = retry;
        lol_n   = lol_count;
        if (restart_req) begin
            st_n    = RST_ASSERT;
            cnt_n   = '0;
            retry_n = '0;
        end else begin
            case (st)
                RST_ASSERT: if (cnt == RST_LAST) begin
                    st_n  = WAIT_LOCK;
                    cnt_n = '0;
                end
                WAIT_LOCK: if (locked_s) begin
                    st_n  = STABLE;
                    cnt_n = '0;
                end else if (cnt == TO_LAST) begin
                    retry_n = retry_inc;
                    cnt_n   = '0;
                    st_n    = (retry_inc == MAX_R) ? FAULT : RST_ASSERT;
                end
                STABLE: if (!locked_s) begin
                    st_n  = WAIT_LOCK;
                    cnt_n = '0;
                end else if (cnt == STB_LAST) begin
                    st_n    = READY;
                    cnt_n   = '0;
                    retry_n = '0;
                end
                READY: begin
                    cnt_n = '0;
                    if (!locked_s) begin
                        st_n  = RST_ASSERT;
                        lol_n = (&lol_count) ? lol_count : lol_count + 8'd1;
                    end
                end
                FAULT: cnt_n = '0;
                default: begin
                    st_n  = RST_ASSERT;
                    cnt_n = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= RST_ASSERT;
            cnt       <= '0;
            retry     <= '0;
            lol_count <= '0;
            pll_rst   <= 1'b1;
            pll_ready <= 1'b0;
            fault     <= 1'b0;
        end else if (!rst_go) begin
            st        <= RST_ASSERT;
            cnt       <= '0;
            retry     <= '0;
            pll_rst   <= 1'b1;
            pll_ready <= 1'b0;
            fault     <= 1'b0;
        end else begin
            st        <= st_n;
            cnt       <= cnt_n;
            retry     <= retry_n;
            lol_count <= lol_n;
            pll_rst   <= (st_n == RST_ASSERT) || (st_n == FAULT);
            pll_ready <= (st_n == READY);
            fault     <= (st_n == FAULT);
        end
    end
endmodule
